// File: rtl/pong_sched_pkg.sv
// rtl/pong_sched_pkg.sv - shared constants and types for the tick scheduler
// Contents:
//   register word addresses, arbiter state type, channel count limit, id width
package pong_sched_pkg;

    localparam int MAX_NCH = 8;
    localparam int ID_W    = 3;
    localparam int DATA_W  = 16;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_ENABLE   = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_CHAN_SEL = 3'd3;
    localparam logic [2:0] ADDR_RELOAD   = 3'd4;
    localparam logic [2:0] ADDR_COUNT    = 3'd5;
    localparam logic [2:0] ADDR_ONESHOT  = 3'd6;
    localparam logic [2:0] ADDR_OVERRUN  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pong_sched_channel.sv
// rtl/pong_sched_channel.sv - one tick divider: down-counter, reload register, expiry
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   tick_in           base tick pulse
//   enable            channel enable (counts only while high)
//   load              force count <= reload (count write or enable rising)
//   reload_we         store reload_wdata into reload
//   reload_wdata      new reload value
//   expire            combinational: this tick expires the channel
//   count, reload     current counter and reload values for readback
module pong_sched_channel
    import pong_sched_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick_in,
    input  logic          enable,
    input  logic          load,
    input  logic          reload_we,
    input  logic [CW-1:0] reload_wdata,
    output logic          expire,
    output logic [CW-1:0] count,
    output logic [CW-1:0] reload
);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] reload_q, reload_d;

    always_comb begin
        expire   = tick_in && enable && (count_q == '0);
        reload_d = reload_we ? reload_wdata : reload_q;
        count_d  = count_q;
        // A tick in the same cycle as a reload write still sees the old reload.
        if (load) begin
            count_d = reload_q;
        end else if (tick_in && enable) begin
            count_d = expire ? reload_q : (count_q - CW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    assign count  = count_q;
    assign reload = reload_q;

endmodule

// File: rtl/pong_tick_scheduler.sv
// rtl/pong_tick_scheduler.sv - multi-channel tick scheduler with round-robin event port
// Optional feature macro: SCHED_ONESHOT_EN (per-channel one-shot mask at register 6)
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   tick_in                         base tick pulse from the interval timer
//   address, chipselect, write_n,
//   writedata, readdata             Avalon-MM slave; readdata registered from address
//   irq                             |(pending & irq_mask)
//   evt_valid, evt_id, evt_ready    single-consumer event handshake
module pong_tick_scheduler
    import pong_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_in,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    input  logic              evt_ready
);

    localparam logic [ID_W:0] NCH_W = (ID_W+1)'(NCH);

    logic                wr_en;
    logic [NCH-1:0]      wdata_ch;

    logic [NCH-1:0]      pending_q, pending_d;
    logic [NCH-1:0]      enable_q, enable_d;
    logic [NCH-1:0]      irq_mask_q, irq_mask_d;
    logic [NCH-1:0]      overrun_q, overrun_d;
    logic [NCH-1:0]      evt_req_q, evt_req_d;
    logic [ID_W-1:0]     chan_sel_q, chan_sel_d;
    logic [DATA_W-1:0]   readdata_q, readdata_d;
`ifdef SCHED_ONESHOT_EN
    logic [NCH-1:0]      oneshot_q, oneshot_d;
`endif

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     evt_id_q, evt_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     rr_off, rr_pick;
    logic [ID_W:0]       pick_sum, next_sum;
    logic [NCH-1:0]      req_rot;
    logic [NCH-1:0]      evt_clr;

    logic [NCH-1:0]      expire;
    logic [NCH-1:0]      ch_load;
    logic [NCH-1:0]      ch_reload_we;
    logic [CW-1:0]       ch_count  [NCH];
    logic [CW-1:0]       ch_reload [NCH];

    assign wr_en    = chipselect && !write_n;
    assign wdata_ch = writedata[NCH-1:0];

    // Per-channel write strobes; an enable 0->1 write restarts the count from reload.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_reload_we[i] = wr_en && (address == ADDR_RELOAD) && (int'(chan_sel_q) == i);
            ch_load[i]      = wr_en && (((address == ADDR_COUNT) && (int'(chan_sel_q) == i)) ||
                                        ((address == ADDR_ENABLE) && wdata_ch[i] && !enable_q[i]));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pong_sched_channel #(.CW(CW)) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .tick_in      (tick_in),
            .enable       (enable_q[g]),
            .load         (ch_load[g]),
            .reload_we    (ch_reload_we[g]),
            .reload_wdata (writedata[CW-1:0]),
            .expire       (expire[g]),
            .count        (ch_count[g]),
            .reload       (ch_reload[g])
        );
    end

    // Register file; expiry is applied after the bus write so set beats W1C.
    always_comb begin
        pending_d  = pending_q;
        enable_d   = enable_q;
        irq_mask_d = irq_mask_q;
        overrun_d  = overrun_q;
        chan_sel_d = chan_sel_q;
`ifdef SCHED_ONESHOT_EN
        oneshot_d  = oneshot_q;
`endif
        if (wr_en) begin
            case (address)
                ADDR_PENDING:  pending_d  = pending_q & ~wdata_ch;
                ADDR_ENABLE:   enable_d   = wdata_ch;
                ADDR_IRQ_MASK: irq_mask_d = wdata_ch;
                ADDR_CHAN_SEL: chan_sel_d = writedata[ID_W-1:0];
`ifdef SCHED_ONESHOT_EN
                ADDR_ONESHOT:  oneshot_d  = wdata_ch;
`endif
                ADDR_OVERRUN:  overrun_d  = overrun_q & ~wdata_ch;
                default: ;
            endcase
        end
        pending_d = pending_d | expire;
        // An expiry that finds its event still queued is counted as an overrun.
        overrun_d = overrun_d | (expire & evt_req_q);
`ifdef SCHED_ONESHOT_EN
        enable_d  = enable_d & ~(expire & oneshot_q);
`endif
        evt_req_d = (evt_req_q & ~evt_clr) | expire;
    end

    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_rot = NCH'({evt_req_q, evt_req_q} >> rr_ptr_q);
        rr_off  = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                rr_off = ID_W'(j);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
        if (pick_sum >= NCH_W) begin
            pick_sum = pick_sum - NCH_W;
        end
        rr_pick  = pick_sum[ID_W-1:0];

        next_sum = {1'b0, evt_id_q} + (ID_W+1)'(1);
        if (next_sum >= NCH_W) begin
            next_sum = '0;
        end

        state_d  = state_q;
        evt_id_d = evt_id_q;
        rr_ptr_d = rr_ptr_q;
        evt_clr  = '0;
        case (state_q)
            IDLE: begin
                if (|evt_req_q) begin
                    evt_id_d = rr_pick;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    for (int i = 0; i < NCH; i++) begin
                        evt_clr[i] = (int'(evt_id_q) == i);
                    end
                    rr_ptr_d = next_sum[ID_W-1:0];
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read mux sampled every cycle; out-of-range chan_sel reads 0 at reload/count.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_PENDING:  readdata_d[NCH-1:0]  = pending_q;
            ADDR_ENABLE:   readdata_d[NCH-1:0]  = enable_q;
            ADDR_IRQ_MASK: readdata_d[NCH-1:0]  = irq_mask_q;
            ADDR_CHAN_SEL: readdata_d[ID_W-1:0] = chan_sel_q;
            ADDR_RELOAD: begin
                for (int i = 0; i < NCH; i++) begin
                    if (int'(chan_sel_q) == i) begin
                        readdata_d[CW-1:0] = ch_reload[i];
                    end
                end
            end
            ADDR_COUNT: begin
                for (int i = 0; i < NCH; i++) begin
                    if (int'(chan_sel_q) == i) begin
                        readdata_d[CW-1:0] = ch_count[i];
                    end
                end
            end
`ifdef SCHED_ONESHOT_EN
            ADDR_ONESHOT:  readdata_d[NCH-1:0]  = oneshot_q;
`endif
            ADDR_OVERRUN:  readdata_d[NCH-1:0]  = overrun_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            enable_q   <= '0;
            irq_mask_q <= '0;
            overrun_q  <= '0;
            evt_req_q  <= '0;
            chan_sel_q <= '0;
            readdata_q <= '0;
`ifdef SCHED_ONESHOT_EN
            oneshot_q  <= '0;
`endif
            state_q    <= IDLE;
            evt_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            irq_mask_q <= irq_mask_d;
            overrun_q  <= overrun_d;
            evt_req_q  <= evt_req_d;
            chan_sel_q <= chan_sel_d;
            readdata_q <= readdata_d;
`ifdef SCHED_ONESHOT_EN
            oneshot_q  <= oneshot_d;
`endif
            state_q    <= state_d;
            evt_id_q   <= evt_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign readdata  = readdata_q;
    assign irq       = |(pending_q & irq_mask_q);
    assign evt_valid = (state_q == OFFER);
    assign evt_id    = evt_id_q;

endmodule
